// File: rtl/fifo_word_packer_if.sv
// Bus bundle between sync_fifo read port, fifo_word_packer and the packed-word consumer.
// master = packer view (reads the FIFO, drives the output stream); slave = environment view.
interface fifo_word_packer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4
);
    localparam int unsigned WORD_W = DATA_WIDTH * RATIO;
    localparam int unsigned NB_W   = $clog2(RATIO + 1);

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_r_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_data;
    logic [NB_W-1:0]       out_nbytes;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_r_en, out_valid, out_data, out_nbytes
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_r_en, out_valid, out_data, out_nbytes
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains byte entries from sync_fifo and packs RATIO of them into one little-endian word.
// Optional partial-word flush after an idle timeout: define FIFO_PACK_TIMEOUT_EN.
module fifo_word_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic clk,
    input  logic rst,
    fifo_word_packer_if.master bus
);
    localparam int unsigned WORD_W = DATA_WIDTH * RATIO;
    localparam int unsigned CNT_W  = $clog2(RATIO + 1);

    logic [CNT_W-1:0]  cnt;
    logic              pend;
    logic [WORD_W-1:0] asm_q;
    logic              slot_free;
    logic              full;
    logic              xfer;
    logic              flush;

    // Issue a read only if the entry (plus any in flight) still fits the assembly register.
    always_comb begin
        slot_free     = !bus.out_valid || bus.out_ready;
        full          = (cnt == CNT_W'(RATIO));
        xfer          = full && slot_free;
        bus.fifo_r_en = !rst && !bus.fifo_empty &&
                        (((CNT_W+1)'(cnt) + (CNT_W+1)'(pend)) < (CNT_W+1)'(RATIO));
    end

`ifdef FIFO_PACK_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] idle_q;

    // Flush waits for an idle partial word with nothing in flight and a free slot.
    always_comb begin
        flush = (idle_q == TMR_W'(TIMEOUT)) && (cnt != '0) && !full && !pend && slot_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else if (pend || flush || xfer) begin
            idle_q <= '0;
        end else if ((cnt != '0) && bus.fifo_empty && (idle_q != TMR_W'(TIMEOUT))) begin
            idle_q <= idle_q + TMR_W'(1);
        end
    end
`else
    always_comb begin
        flush = 1'b0;
    end
`endif

    // Assembly, pending-read tracking and output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            pend           <= 1'b0;
            asm_q          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_nbytes <= '0;
        end else begin
            pend <= bus.fifo_r_en;
            if (xfer || flush) begin
                bus.out_data   <= asm_q;
                bus.out_nbytes <= xfer ? CNT_W'(RATIO) : cnt;
                bus.out_valid  <= 1'b1;
                cnt            <= '0;
                asm_q          <= '0;
            end else begin
                if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                end
                if (pend) begin
                    asm_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_rd_data;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural sync_fifo and a word scoreboard.
module tb_fifo_word_packer;
    localparam int unsigned DW = 8;
    localparam int unsigned R  = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  nb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fifo_rst = 1'b0;
    logic w_en = 1'b0;
    logic [7:0] wdata = '0;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int words_seen = 0;
    int underflow = 0;

    exp_t exp_q[$];
    logic [7:0] fmem[$];
    logic [31:0] acc = '0;
    int acc_n = 0;

    fifo_word_packer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

    fifo_word_packer #(.DATA_WIDTH(DW), .RATIO(R), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural sync_fifo: read data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (fifo_rst) begin
            fmem.delete();
            bus.fifo_rd_data <= '0;
            bus.fifo_empty   <= 1'b1;
        end else begin
            if (bus.fifo_r_en === 1'b1) begin
                if (fmem.size() == 0) underflow++;
                else bus.fifo_rd_data <= fmem.pop_front();
            end
            if (w_en) fmem.push_back(wdata);
            bus.fifo_empty <= (fmem.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (bus.fifo_r_en === 1'b1) rd_cnt++;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            exp_t e;
            words_seen++;
            chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_nbytes", 32'(bus.out_nbytes), 32'(e.nb));
            end
        end
    end

    task automatic put_byte(input logic [7:0] b, input bit track);
        w_en  = 1'b1;
        wdata = b;
        if (track) begin
            acc[acc_n*8 +: 8] = b;
            acc_n++;
            if (acc_n == R) begin
                exp_q.push_back('{data: acc, nb: 3'(R)});
                acc   = '0;
                acc_n = 0;
            end
        end
        @(posedge clk); #1;
        w_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.out_valid === 1'b0) break;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset held while the FIFO fills: nothing may be read or presented.
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                w_en  = 1'b1;
                wdata = 8'(i + 1);
                acc[acc_n*8 +: 8] = wdata;
                acc_n++;
            end
            @(negedge clk);
            chk("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_data", bus.out_data, 32'd0);
            chk("rst_nbytes", 32'(bus.out_nbytes), 32'd0);
            @(posedge clk); #1;
            w_en = 1'b0;
        end
        exp_q.push_back('{data: acc, nb: 3'(R)});
        acc = '0;
        acc_n = 0;

        // Basic packing.
        rst = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain(50);
        chk("basic_words", 32'(words_seen), 32'd1);
        chk("basic_empty", 32'(bus.fifo_empty), 32'd1);

        // Back-pressure: two words worth of entries, then stall.
        bus.out_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) put_byte(8'(8'h10 + i), 1'b1);
        idle(20);
        @(negedge clk);
        chk("bp_reads", 32'(rd_cnt), 32'd8);
        chk("bp_r_en", 32'(bus.fifo_r_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold", bus.out_data, 32'h13121110);
            chk("bp_nbytes", 32'(bus.out_nbytes), 32'd4);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain(50);
        chk("bp_words", 32'(words_seen), 32'd3);

        // Random stream with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            put_byte(8'($urandom_range(0, 255)), 1'b1);
            bus.out_ready = 1'($urandom_range(0, 1));
            idle(1);
        end
        bus.out_ready = 1'b1;
        wait_drain(300);
        chk("rand_words", 32'(words_seen), 32'd18);

        // Reset in the middle of an assembly discards the partial word.
        put_byte(8'h55, 1'b0);
        put_byte(8'h66, 1'b0);
        idle(4);
        rst = 1'b1;
        fifo_rst = 1'b1;
        idle(1);
        rst = 1'b0;
        fifo_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        put_byte(8'hAA, 1'b1);
        put_byte(8'hBB, 1'b1);
        put_byte(8'hCC, 1'b1);
        put_byte(8'hDD, 1'b1);
        wait_drain(50);
        chk("mid_rst_words", 32'(words_seen), 32'd19);

        // Partial word left idle.
        put_byte(8'h11, 1'b0);
        put_byte(8'h22, 1'b0);
        put_byte(8'h33, 1'b0);
`ifdef FIFO_PACK_TIMEOUT_EN
        exp_q.push_back('{data: 32'h00332211, nb: 3'd3});
        wait_drain(60);
        chk("timeout_words", 32'(words_seen), 32'd20);
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("no_timeout_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        chk("no_timeout_words", 32'(words_seen), 32'd19);
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("no_underflow", 32'(underflow), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Read-side consumer that sits directly downstream of sync_fifo.
- Drains 8-bit entries from the FIFO using its r_en/rd_data/empty interface and packs RATIO consecutive entries into one wide word.
- Presents each packed word on a valid/ready output stream.
- Accounts for the FIFO's one-cycle read latency and never over-reads when the output is back-pressured.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry.
- RATIO, 4, FIFO entries per output word; legal range >= 2.
- TIMEOUT, 16, idle cycles before a partial word is flushed; used only with the optional feature; legal range >= 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  empty flag from sync_fifo.
- fifo_rd_data  in  DATA_WIDTH  sync_fifo read data; valid the cycle after an accepted read.
- fifo_r_en  out  1  read enable to sync_fifo.
- out_valid  out  1  packed word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_WIDTH*RATIO  packed word; first-read entry in bits [DATA_WIDTH-1:0] (little-endian lanes).
- out_nbytes  out  $clog2(RATIO+1)  number of valid lanes in out_data.

Behaviour:
- Interface (already decided): one clock, clk; reset rst, synchronous and active-high.
- Reset (rst=1 at a posedge):
  - Clears the assembly count (cnt), pending flag (pend), idle timer, out_valid, out_data and out_nbytes to 0.
  - fifo_r_en is forced to 0 while rst=1.
- Read issue (combinational): fifo_r_en = !rst && !fifo_empty && (cnt + pend < RATIO).
- Pending flag: pend <= fifo_r_en at each posedge. This is the FIFO's one-cycle read latency.
- Capture: when pend=1, fifo_rd_data is written into lane [cnt] of the assembly register and cnt increments.
  - The issue rule guarantees cnt < RATIO whenever pend=1, so no overflow is possible.
- Transfer: when cnt==RATIO and the output slot is free (!out_valid || out_ready):
  - out_data <= assembly register; out_nbytes <= RATIO; out_valid <= 1; cnt <= 0.
  - When cnt==RATIO, pend is always 0, so transfer and capture never collide.
- Output handshake:
  - out_valid=1 with out_ready=0: out_data and out_nbytes hold stable.
  - out_valid=1 with out_ready=1 and no new transfer: out_valid drops next cycle.
  - Accept and transfer in the same cycle: out_valid stays 1 and the new word is loaded (back-to-back words).
- Back-pressure: once a full word sits in the assembly register and the output slot is occupied, reads stop. At most 2*RATIO entries are held inside the block.
- Throughput: with the FIFO continuously non-empty and out_ready=1, RATIO entries per RATIO+2 cycles.
- Reset mid-operation:
  - Partial assembly and any in-flight entry (pend=1) are discarded.
  - A word held on the output is dropped.
  - The FIFO is reset by the same rst.
- fifo_empty during pend: has no effect. The entry was already accepted by the FIFO and is captured normally.
- Unused lanes (feature only): zero.

Optional Feature:
- Macro: FIFO_PACK_TIMEOUT_EN.
- Defined:
  - An idle timer counts cycles while cnt>0 && pend==0 && fifo_empty. Any capture or reset clears it.
  - When the timer reaches TIMEOUT and the output slot is free, the partial word is flushed: out_data gets the captured lanes with upper lanes zero; out_nbytes=cnt; out_valid=1; cnt and timer return to 0.
  - If the slot is busy, the flush waits for the slot.
- Not defined:
  - No timer logic.
  - Partial words wait indefinitely.
  - out_nbytes is always RATIO whenever out_valid=1.

Test Plan:
1. Reset: hold rst=1 for 10 cycles with the FIFO holding data -> out_valid=0, out_data=0, out_nbytes=0, fifo_r_en=0 throughout.
2. Basic packing: write 0x01,0x02,0x03,0x04 into sync_fifo with out_ready=1 -> exactly one out_valid pulse, out_data=32'h04030201, out_nbytes=4, fifo_empty=1 afterwards.
3. Back-pressure: write 0x10..0x17 with out_ready=0 -> out_data=32'h13121110 held stable; fifo_r_en stops after the 8th entry; raise out_ready -> 32'h13121110 then 32'h17161514 on consecutive accepts; no loss or duplication.
4. Random stream: write 60 random bytes with w_en every other cycle and toggle out_ready randomly -> 15 words, each equal to the scoreboard queue's next 4 bytes packed little-endian.
5. Reset mid-assembly: capture 2 entries, pulse rst for 1 cycle, then write 0xAA,0xBB,0xCC,0xDD -> only output is 32'hDDCCBBAA.
6. Timeout: write 0x11,0x22,0x33, then leave the FIFO empty.
   - With FIFO_PACK_TIMEOUT_EN defined -> after 16 idle cycles, out_data=32'h00332211, out_nbytes=3.
   - Without it -> no output for 100 cycles.
